// File: rtl/csr_hpm_counters.sv
// Machine counter / performance-monitor CSR bank: mcycle, minstret and
// NUM_CNT event-selectable mhpmcounters. Provides per-counter inhibit,
// sticky overflow flags with write-1-to-clear, and a registered overflow
// interrupt. Counter index k uses CSR 0xB00+k / 0xB80+k (lo/hi), with
// read-only user shadows at 0xC00+k / 0xC80+k. Index 1 (time) is not
// implemented here and always reads as unmapped.
module csr_hpm_counters #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 64,
  parameter int NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               csr_we,
  input  logic [11:0]        csr_address_wb,
  input  logic [31:0]        csr_wb,
  input  logic [11:0]        csr_address_r,
  input  logic               exception_pending,
  input  logic               instr_retire,
  input  logic [NUM_EVT-1:0] evt,
  output logic [31:0]        csr_data,
  output logic               csr_hit,
  output logic [NUM_CNT+2:0] ovf_status,
  output logic               ovf_irq
);

  localparam int NC = NUM_CNT + 3;
  // Bit 1 (time) is never implemented in inhibit or overflow registers.
  localparam logic [NC-1:0] IMPL_MASK = {{NUM_CNT{1'b1}}, 3'b101};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]   cnt_q [NC];
  logic [7:0]         sel_q [NUM_CNT];
  logic [NUM_CNT-1:0] ovie_q;
  logic [NC-1:0]      inh_q;
  logic [NC-1:0]      ovf_q;
  logic               ovf_irq_q;

  logic               wr_en;
  logic [NC-1:0]      wr_lo;
  logic [NC-1:0]      wr_hi;
  logic [NUM_CNT-1:0] wr_evt;
  logic               wr_inh;
  logic               wr_ovf;
  logic [NUM_CNT-1:0] evt_hit;
  logic [NC-1:0]      inc;
  logic [NC-1:0]      ovf_set;
  logic [NC-1:0]      ovf_clr;
  logic [NC-1:0]      ovf_d;
  logic               irq_d;
  logic [63:0]        cnt_ext [NC];

  // Write address decode; a pending exception squashes every write.
  always_comb begin
    wr_en  = csr_we && !exception_pending;
    wr_lo  = '0;
    wr_hi  = '0;
    wr_evt = '0;
    for (int k = 0; k < NC; k++) begin
      if (k != 1) begin
        wr_lo[k] = wr_en && (csr_address_wb == (12'hB00 + 12'(k)));
        wr_hi[k] = wr_en && (csr_address_wb == (12'hB80 + 12'(k)));
      end
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      wr_evt[i] = wr_en && (csr_address_wb == (12'h323 + 12'(i)));
    end
    wr_inh = wr_en && (csr_address_wb == 12'h320);
    wr_ovf = wr_en && (csr_address_wb == 12'h7D0);
  end

  // Per-counter increment enables; out-of-range selectors never match.
  always_comb begin
    evt_hit = '0;
    inc     = '0;
    inc[0]  = !inh_q[0];
    inc[2]  = instr_retire && !inh_q[2];
    for (int i = 0; i < NUM_CNT; i++) begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if ((sel_q[i] == 8'(e + 1)) && evt[e]) begin
          evt_hit[i] = 1'b1;
        end
      end
      inc[3+i] = !inh_q[3+i] && evt_hit[i];
    end
  end

  // Overflow flag next state: a wrap that is not overridden by a write sets
  // the flag, and a set beats a simultaneous write-1-to-clear.
  always_comb begin
    ovf_set = '0;
    for (int k = 0; k < NC; k++) begin
      ovf_set[k] = inc[k] && !wr_lo[k] && !wr_hi[k] && (cnt_q[k] == CNT_MAX);
    end
    ovf_clr = wr_ovf ? csr_wb[NC-1:0] : '0;
    ovf_d   = ((ovf_q & ~ovf_clr) | ovf_set) & IMPL_MASK;
    irq_d   = ovf_q[0] | ovf_q[2] | (|(ovf_q[NC-1:3] & ovie_q));
  end

  // Counter registers: a write to either half wins over that cycle's increment.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < NC; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (wr_lo[k]) begin
          cnt_q[k][31:0] <= csr_wb;
        end else if (wr_hi[k]) begin
          cnt_q[k][CNT_W-1:32] <= csr_wb[CNT_W-33:0];
        end else if (inc[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_ONE;
        end
      end
    end
  end

  // Configuration, overflow flags and the registered interrupt.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        sel_q[i] <= '0;
      end
      ovie_q    <= '0;
      inh_q     <= '0;
      ovf_q     <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (wr_evt[i]) begin
          sel_q[i]  <= csr_wb[7:0];
          ovie_q[i] <= csr_wb[31];
        end
      end
      if (wr_inh) begin
        inh_q <= csr_wb[NC-1:0] & IMPL_MASK;
      end
      ovf_q     <= ovf_d;
      ovf_irq_q <= irq_d;
    end
  end

  // Combinational read mux with zero-extension of narrow counters.
  always_comb begin
    csr_data = '0;
    csr_hit  = 1'b0;
    for (int k = 0; k < NC; k++) begin
      cnt_ext[k]            = '0;
      cnt_ext[k][CNT_W-1:0] = cnt_q[k];
    end
    for (int k = 0; k < NC; k++) begin
      if (k != 1) begin
        if ((csr_address_r == (12'hB00 + 12'(k))) || (csr_address_r == (12'hC00 + 12'(k)))) begin
          csr_data = cnt_ext[k][31:0];
          csr_hit  = 1'b1;
        end
        if ((csr_address_r == (12'hB80 + 12'(k))) || (csr_address_r == (12'hC80 + 12'(k)))) begin
          csr_data = cnt_ext[k][63:32];
          csr_hit  = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (csr_address_r == (12'h323 + 12'(i))) begin
        csr_data = {ovie_q[i], 23'b0, sel_q[i]};
        csr_hit  = 1'b1;
      end
    end
    if (csr_address_r == 12'h320) begin
      csr_data = 32'(inh_q);
      csr_hit  = 1'b1;
    end
    if (csr_address_r == 12'h7D0) begin
      csr_data = 32'(ovf_q);
      csr_hit  = 1'b1;
    end
  end

  assign ovf_status = ovf_q;
  assign ovf_irq    = ovf_irq_q;

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Directed bench for csr_hpm_counters (NUM_CNT=4, CNT_W=64, NUM_EVT=8).
// Inputs change just after the falling edge; outputs are read shortly after
// the falling edge, well away from the rising edge.
module tb_csr_hpm_counters;

  logic        clk;
  logic        nrst;
  logic        csr_we;
  logic [11:0] csr_address_wb;
  logic [31:0] csr_wb;
  logic [11:0] csr_address_r;
  logic        exception_pending;
  logic        instr_retire;
  logic [7:0]  evt;
  logic [31:0] csr_data;
  logic        csr_hit;
  logic [6:0]  ovf_status;
  logic        ovf_irq;

  int n_checks = 0;
  int n_errors = 0;

  csr_hpm_counters #(
    .NUM_CNT(4),
    .CNT_W  (64),
    .NUM_EVT(8)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .csr_we           (csr_we),
    .csr_address_wb   (csr_address_wb),
    .csr_wb           (csr_wb),
    .csr_address_r    (csr_address_r),
    .exception_pending(exception_pending),
    .instr_retire     (instr_retire),
    .evt              (evt),
    .csr_data         (csr_data),
    .csr_hit          (csr_hit),
    .ovf_status       (ovf_status),
    .ovf_irq          (ovf_irq)
  );

  // Clock: 100-unit period, rising edges at 50, 150, ...
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One write strobe spanning exactly one rising edge.
  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data, input logic exc);
    csr_we            = 1'b1;
    csr_address_wb    = addr;
    csr_wb            = data;
    exception_pending = exc;
    @(negedge clk);
    csr_we            = 1'b0;
    exception_pending = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_address_r = addr;
    #1;
    check(tag, csr_data, exp);
  endtask

  task automatic hit_chk(input string tag, input logic [11:0] addr, input logic exp);
    csr_address_r = addr;
    #1;
    check(tag, {31'b0, csr_hit}, {31'b0, exp});
  endtask

  initial begin
    nrst              = 1'b0;
    csr_we            = 1'b0;
    csr_address_wb    = '0;
    csr_wb            = '0;
    csr_address_r     = '0;
    exception_pending = 1'b0;
    instr_retire      = 1'b0;
    evt               = '0;
    tick(2);

    // Reset state
    rd_chk("rst_mcycle", 12'hB00, 32'h0);
    check("rst_irq", {31'b0, ovf_irq}, 32'h0);
    nrst = 1'b1;

    // 1: free-running mcycle, everything else idle
    tick(10);
    rd_chk("t1_mcycle_lo", 12'hB00, 32'd10);
    rd_chk("t1_mcycle_hi", 12'hB80, 32'h0);
    rd_chk("t1_minstret", 12'hB02, 32'h0);
    rd_chk("t1_hpm3", 12'hB03, 32'h0);
    rd_chk("t1_hpm6", 12'hB06, 32'h0);
    check("t1_ovf", {25'b0, ovf_status}, 32'h0);
    check("t1_irq", {31'b0, ovf_irq}, 32'h0);
    rd_chk("t1_unmapped_data", 12'h123, 32'h0);
    hit_chk("t1_unmapped_hit", 12'h123, 1'b0);
    hit_chk("t1_mcycle_hit", 12'hB00, 1'b1);
    hit_chk("t1_time_hit", 12'hB01, 1'b0);
    hit_chk("t1_evt7_hit", 12'h327, 1'b0);
    hit_chk("t1_ovfreg_hit", 12'h7D0, 1'b1);

    // 2: event selection
    csr_write(12'h323, 32'h8000_0002, 1'b0);
    evt = 8'h02;
    tick(5);
    evt = 8'h00;
    rd_chk("t2_hpm3_5", 12'hB03, 32'd5);
    rd_chk("t2_evt3_rd", 12'h323, 32'h8000_0002);
    csr_write(12'h323, 32'h0000_0009, 1'b0);
    csr_write(12'hB03, 32'h0, 1'b0);
    evt = 8'hFF; tick(1);
    evt = 8'h00; tick(1);
    evt = 8'hFF; tick(3);
    evt = 8'h00;
    rd_chk("t2_hpm3_sel9", 12'hB03, 32'h0);
    rd_chk("t2_hpm4_sel0", 12'hB04, 32'h0);

    // 3: wrap, overflow flag, interrupt, W1C
    csr_write(12'h323, 32'h8000_0002, 1'b0);
    csr_write(12'hB83, 32'hFFFF_FFFF, 1'b0);
    csr_write(12'hB03, 32'hFFFF_FFFE, 1'b0);
    rd_chk("t3_hpm3_hi", 12'hB83, 32'hFFFF_FFFF);
    rd_chk("t3_hpm3_shadow", 12'hC03, 32'hFFFF_FFFE);
    evt = 8'h02;
    tick(1);
    rd_chk("t3_hpm3_max", 12'hB03, 32'hFFFF_FFFF);
    check("t3_ovf_pre", {25'b0, ovf_status}, 32'h0);
    tick(1);
    evt = 8'h00;
    rd_chk("t3_wrap_lo", 12'hB03, 32'h0);
    rd_chk("t3_wrap_hi", 12'hB83, 32'h0);
    check("t3_ovf_set", {25'b0, ovf_status}, 32'h8);
    check("t3_irq_lag", {31'b0, ovf_irq}, 32'h0);
    rd_chk("t3_ovf_rd", 12'h7D0, 32'h8);
    tick(1);
    check("t3_irq_set", {31'b0, ovf_irq}, 32'h1);
    csr_write(12'h7D0, 32'h8, 1'b0);
    check("t3_ovf_clr", {25'b0, ovf_status}, 32'h0);
    check("t3_irq_hold", {31'b0, ovf_irq}, 32'h1);
    tick(1);
    check("t3_irq_clr", {31'b0, ovf_irq}, 32'h0);

    // 4: counter writes while counting, squashed and read-only writes
    csr_write(12'hB80, 32'h5, 1'b0);
    csr_write(12'hB00, 32'h100, 1'b0);
    rd_chk("t4_lo_wr", 12'hB00, 32'h100);
    rd_chk("t4_hi_kept", 12'hB80, 32'h5);
    tick(1);
    rd_chk("t4_lo_next", 12'hB00, 32'h101);
    csr_write(12'hB00, 32'h100, 1'b1);
    rd_chk("t4_exc_drop", 12'hB00, 32'h102);
    csr_write(12'hC00, 32'h0, 1'b0);
    rd_chk("t4_shadow_ro", 12'hB00, 32'h103);
    rd_chk("t4_shadow_hi", 12'hC80, 32'h5);

    // 5: inhibit
    csr_write(12'h320, 32'h5, 1'b0);
    rd_chk("t5_inh_edge", 12'hB00, 32'h104);
    for (int i = 0; i < 20; i++) begin
      instr_retire = i[0];
      tick(1);
    end
    instr_retire = 1'b0;
    rd_chk("t5_cy_frozen", 12'hB00, 32'h104);
    rd_chk("t5_ir_frozen", 12'hB02, 32'h0);
    rd_chk("t5_inh_rd", 12'h320, 32'h5);
    instr_retire = 1'b1;
    csr_write(12'h320, 32'h0, 1'b0);
    rd_chk("t5_ir_wr_edge", 12'hB02, 32'h0);
    tick(3);
    instr_retire = 1'b0;
    rd_chk("t5_ir_resume", 12'hB02, 32'h3);
    rd_chk("t5_cy_resume", 12'hB00, 32'h107);
    csr_write(12'h320, 32'hFFFF_FFFF, 1'b0);
    rd_chk("t5_inh_mask", 12'h320, 32'h7D);
    csr_write(12'h320, 32'h0, 1'b0);
    rd_chk("t5_cy_after", 12'hB00, 32'h108);

    // 6: wrap and W1C of the same flag in one cycle
    csr_write(12'hB83, 32'hFFFF_FFFF, 1'b0);
    csr_write(12'hB03, 32'hFFFF_FFFF, 1'b0);
    evt = 8'h02;
    csr_write(12'h7D0, 32'h8, 1'b0);
    evt = 8'h00;
    check("t6_set_wins", {25'b0, ovf_status}, 32'h8);
    rd_chk("t6_wrap_lo", 12'hB03, 32'h0);
    tick(1);
    check("t6_irq", {31'b0, ovf_irq}, 32'h1);
    csr_write(12'h7D0, 32'h8, 1'b0);
    tick(1);
    check("t6_irq_clr", {31'b0, ovf_irq}, 32'h0);

    // OVIE clear: flag sets but no interrupt
    csr_write(12'h324, 32'h1, 1'b0);
    csr_write(12'hB84, 32'hFFFF_FFFF, 1'b0);
    csr_write(12'hB04, 32'hFFFF_FFFF, 1'b0);
    evt = 8'h01;
    tick(1);
    evt = 8'h00;
    check("t7_ovf4", {25'b0, ovf_status}, 32'h10);
    tick(1);
    check("t7_no_irq", {31'b0, ovf_irq}, 32'h0);
    rd_chk("t7_evt4_rd", 12'h324, 32'h1);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #20 nrst = 1'b0;
    #1;
    check("t8_rst_ovf", {25'b0, ovf_status}, 32'h0);
    rd_chk("t8_rst_mcycle", 12'hB00, 32'h0);
    rd_chk("t8_rst_evt3", 12'h323, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    tick(3);
    rd_chk("t8_resume", 12'hB00, 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_hpm_counters.md
Name: csr_hpm_counters

Overview:
- Parametrised machine counter/performance-monitor CSR bank for the core: mcycle, minstret, and NUM_CNT programmable mhpmcounters with event selection, inhibit, overflow flags and an overflow interrupt.
- Sits beside the main CSR register file and shares its CSR read/write address buses.
- The core muxes csr_rdata in when csr_hit is high.
- Next generation of the fixed free-running timer: configurable counter width, channel count and events.

Parameters:
- NUM_CNT, 4, number of mhpmcounter channels (1..29), mapped to counter indices 3..3+NUM_CNT-1.
- CNT_W, 64, counter width in bits (33..64); applies to mcycle, minstret and all mhpmcounters.
- NUM_EVT, 8, number of event inputs (1..255).

Ports:
- clk  input  1  clock.
- nrst  input  1  reset; asynchronous, active-low.
- csr_we  input  1  CSR write strobe.
- csr_address_wb  input  12  CSR write address.
- csr_wb  input  32  CSR write data.
- csr_address_r  input  12  CSR read address.
- exception_pending  input  1  blocks all CSR writes while high.
- instr_retire  input  1  one instruction retired this cycle.
- evt  input  NUM_EVT  per-cycle event pulses.
- csr_data  output  32  combinational read data.
- csr_hit  output  1  csr_address_r decodes to a CSR implemented here.
- ovf_status  output  NUM_CNT+3  current overflow flags (bit i = counter index i; bit 1 is always 0).
- ovf_irq  output  1  registered overflow interrupt request.

Behaviour:
- CSR map:
  - mcycle 0xB00/0xB80 (lo/hi); minstret 0xB02/0xB82.
  - mhpmcounter(3+i) at 0xB03+i / 0xB83+i.
  - mhpmevent(3+i) at 0x323+i: bits [7:0] sel, bit 31 OVIE; other bits read 0.
  - mcountinhibit 0x320: bit0 CY, bit2 IR, bit 3+i HPM; unimplemented bits read 0.
  - mcounterovf 0x7D0: read flags, write-1-to-clear.
  - User read-only shadows 0xC00/0xC80, 0xC02/0xC82, 0xC03+i/0xC83+i: writes ignored.
- Unmapped read address: csr_data=0 and csr_hit=0.
- Counter bits above CNT_W read as 0; the high-half read returns {zero pad, cnt[CNT_W-1:32]}.
- Reset: all counters, mhpmevent, mcountinhibit and ovf flags are 0; ovf_irq=0.
- Increment conditions, evaluated each cycle:
  - mcycle: +1 when !CY.
  - minstret: +1 when instr_retire && !IR.
  - HPM i: +1 when !HPM[i] && sel!=0 && sel<=NUM_EVT && evt[sel-1].
  - sel=0 or sel>NUM_EVT: never counts.
- Latency: an event at cycle N is visible on csr_data at cycle N+1.
- Writes:
  - Take effect when csr_we && !exception_pending. Any write with exception_pending high is dropped.
  - Low-half write loads cnt[31:0] and keeps the upper bits; high-half write loads cnt[CNT_W-1:32] from csr_wb[CNT_W-33:0].
  - A write to a counter in the same cycle as its increment: the write wins and that increment is lost.
- Wrap: increment from all-ones gives 0 and sets ovf flag i in the same edge. Flags are sticky until cleared.
- Overflow clear: mcounterovf write clears flags where csr_wb=1. Simultaneous set and clear of the same flag: set wins.
- ovf_irq is a register updated every cycle to OR over HPM i of (ovf[3+i] && OVIE[i]), OR'd with the mcycle and minstret flags (always enabled). It asserts the cycle after the flag sets.
- Inhibit changes take effect for the increment in the cycle after the write.
- Async reset mid-count clears everything immediately; counting resumes on the first clk edge after nrst deasserts.

Test Plan:
1. Reset release, no writes, 10 clocks → mcycle lo reads 10; minstret 0; all HPM 0; ovf_irq=0; read of 0x123 gives csr_data=0, csr_hit=0.
2. Program mhpmevent3=0x80000002, drive evt[1] high for 5 cycles → mhpmcounter3=5; with sel=0x09 (NUM_EVT=8), evt toggling → counter stays 0.
3. Write mhpmcounter3 hi=0xFFFFFFFF and lo=0xFFFFFFFE, then 2 events → reads 0; ovf_status[3]=1; ovf_irq=1 one cycle after the wrap. W1C 0x8 → flag and ovf_irq clear.
4. Write mcycle lo=0x100 while counting → next read 0x101, upper half unchanged. Same write with exception_pending=1 → ignored, count continues.
5. Set mcountinhibit=0x5 → mcycle and minstret frozen over 20 cycles while instr_retire pulses; clear it → both resume.
6. Wrap event and W1C of the same flag in one cycle → flag remains 1; ovf_irq stays/asserts 1.
